// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imm_pkg
//  Brief    : Shared types and constants for the immediate-generation pipe.
//  Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam int c_DEFAULT_XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extract
//  Brief    : Combinational RV32I immediate field extraction and sign extension.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = c_DEFAULT_XLEN
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      inst_type,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic [31:0] w_imm32;
    logic        w_unused_opcode;

    // The opcode field never contributes to any immediate.
    assign w_unused_opcode = ^inst[6:0];

    always_comb begin
        w_imm32 = '0;
        err     = 1'b0;
        case (inst_type)
            IMM_I:   w_imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   w_imm32 = {inst[31:12], 12'h000};
            IMM_J:   w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: err     = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Brief    : Valid/ready pipelined immediate generator with illegal-type counter.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = c_DEFAULT_XLEN,
    parameter int STAGES = 2,
    parameter int ERRW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [2:0]      inst_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      out_type,
    output logic            out_err,
    output logic [ERRW-1:0] err_count
);

    localparam int              c_LAST    = STAGES - 1;
    localparam logic [ERRW-1:0] c_ERR_MAX = '1;

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "imm_gen_pipe: STAGES must be in 1..4");
    end

    logic [XLEN-1:0]   w_ext_imm;
    logic              w_ext_err;
    logic              w_accept;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_in;
    logic [STAGES-1:0] w_err_in;
    logic [XLEN-1:0]   w_imm_in  [STAGES];
    logic [2:0]        w_type_in [STAGES];

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_err;
    logic [XLEN-1:0]   r_imm  [STAGES];
    logic [2:0]        r_type [STAGES];
    logic [ERRW-1:0]   r_err_count;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .inst      (inst),
        .inst_type (inst_type),
        .imm       (w_ext_imm),
        .err       (w_ext_err)
    );

    assign in_ready = rst_n & w_load[0];
    assign w_accept = in_valid & in_ready;

    // Load enables ripple back from the output so a full pipe moves in lockstep.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == c_LAST) begin : g_tail
            assign w_load[i] = !r_valid[i] | out_ready;
        end else begin : g_mid
            assign w_load[i] = !r_valid[i] | w_load[i+1];
        end

        if (i == 0) begin : g_head
            assign w_valid_in[i] = w_accept;
            assign w_imm_in[i]   = w_ext_imm;
            assign w_type_in[i]  = inst_type;
            assign w_err_in[i]   = w_ext_err;
        end else begin : g_fwd
            assign w_valid_in[i] = r_valid[i-1];
            assign w_imm_in[i]   = r_imm[i-1];
            assign w_type_in[i]  = r_type[i-1];
            assign w_err_in[i]   = r_err[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= w_valid_in[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (w_load[i]) begin
                r_imm[i]  <= w_imm_in[i];
                r_type[i] <= w_type_in[i];
                r_err[i]  <= w_err_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_ext_err && !flush && r_err_count != c_ERR_MAX) begin
            r_err_count <= r_err_count + ERRW'(1);
        end
    end

    assign out_valid = rst_n & r_valid[c_LAST];
    assign imm       = r_imm[c_LAST];
    assign out_type  = r_type[c_LAST];
    assign out_err   = out_valid & r_err[c_LAST];
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_pipe
//  Brief    : Self-checking bench for imm_gen_pipe (32/2, ERRW=2 and 64/4 variants).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  itype;
        logic [31:0] imm;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  itype;
        logic        err;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] inst;
    logic [2:0]  inst_type;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [31:0] a_imm;
    logic [2:0]  a_out_type;
    logic [15:0] a_err_count;

    logic        b_unused_in_ready, b_unused_out_valid, b_unused_out_err;
    logic [31:0] b_unused_imm;
    logic [2:0]  b_unused_out_type;
    logic [1:0]  b_err_count;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err, c_flush;
    logic [31:0] c_inst;
    logic [2:0]  c_inst_type, c_out_type;
    logic [63:0] c_imm;
    logic [15:0] c_unused_err_count;

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .ERRW(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .inst(inst), .inst_type(inst_type), .out_valid(a_out_valid), .out_ready(out_ready),
        .imm(a_imm), .out_type(a_out_type), .out_err(a_out_err), .err_count(a_err_count)
    );

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .ERRW(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_unused_in_ready),
        .inst(inst), .inst_type(inst_type), .out_valid(b_unused_out_valid), .out_ready(out_ready),
        .imm(b_unused_imm), .out_type(b_unused_out_type), .out_err(b_unused_out_err),
        .err_count(b_err_count)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(4), .ERRW(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .inst(c_inst), .inst_type(c_inst_type), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .imm(c_imm), .out_type(c_out_type), .out_err(c_out_err), .err_count(c_unused_err_count)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   exp_err_a = 0;
    int   exp_err_b = 0;
    bit   chk_lat  = 1'b0;
    exp_t cur_exp;
    exp_t sb [$];
    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on retire.
    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_err_a = 0;
            exp_err_b = 0;
        end else begin
            if (a_out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got imm %h type %0d, required no output (cycle %0d)",
                             a_imm, a_out_type, cyc);
                end else begin
                    e = sb.pop_front();
                    check("retire", {a_out_err, a_out_type, a_imm}, {e.err, e.itype, e.imm});
                    if (chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && a_in_ready) begin
                e         = cur_exp;
                e.acc_cyc = cyc;
                sb.push_back(e);
                n_acc++;
                if (cur_exp.err) begin
                    exp_err_a++;
                    if (exp_err_b < 3) exp_err_b++;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        sample();
        adv();
    endtask

    task automatic drive(input vec_t v);
        in_valid      = 1'b1;
        inst          = v.inst;
        inst_type     = v.itype;
        cur_exp.imm   = v.imm;
        cur_exp.itype = v.itype;
        cur_exp.err   = v.err;
    endtask

    task automatic send(input vec_t v);
        bit done = 1'b0;
        drive(v);
        for (int k = 0; k < 40 && !done; k++) begin
            sample();
            done = a_in_ready;
            adv();
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && sb.size() != 0; k++) cycle();
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        cycle();
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   i, t0, n0;

        vecs[0]  = '{32'hF0E1D2C3, 3'd0, 32'hFFFFFF0E, 1'b0};
        vecs[1]  = '{32'hF0E1D2C3, 3'd1, 32'hFFFFFF05, 1'b0};
        vecs[2]  = '{32'hF0E1D2C3, 3'd2, 32'hFFFFFF04, 1'b0};
        vecs[3]  = '{32'hF0E1D2C3, 3'd3, 32'hF0E1D000, 1'b0};
        vecs[4]  = '{32'hF0E1D2C3, 3'd4, 32'hFFF1D70E, 1'b0};
        vecs[5]  = '{32'h7FFFFFFF, 3'd0, 32'h000007FF, 1'b0};
        vecs[6]  = '{32'h7FFFFFFF, 3'd1, 32'h000007FF, 1'b0};
        vecs[7]  = '{32'h7FFFFFFF, 3'd2, 32'h00000FFE, 1'b0};
        vecs[8]  = '{32'h7FFFFFFF, 3'd3, 32'h7FFFF000, 1'b0};
        vecs[9]  = '{32'h7FFFFFFF, 3'd4, 32'h000FFFFE, 1'b0};
        vecs[10] = '{32'h80000000, 3'd0, 32'hFFFFF800, 1'b0};
        vecs[11] = '{32'h80000000, 3'd1, 32'hFFFFF800, 1'b0};
        vecs[12] = '{32'h80000000, 3'd2, 32'hFFFFF000, 1'b0};
        vecs[13] = '{32'h80000000, 3'd3, 32'h80000000, 1'b0};
        vecs[14] = '{32'h80000000, 3'd4, 32'hFFF00000, 1'b0};
        vecs[15] = '{32'h12345678, 3'd5, 32'h00000000, 1'b1};
        vecs[16] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; inst_type = '0; cur_exp = '{32'd0, 3'd0, 1'b0, 0};
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_flush = 1'b0; c_inst = '0; c_inst_type = '0;

        // Reset state
        sample();
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_out_err", 64'(a_out_err), 64'd0);
        check("rst_err_count", 64'(a_err_count), 64'd0);
        check("rst_c_in_ready", 64'(c_in_ready), 64'd0);
        adv();
        cycle();
        rst_n = 1'b1;
        sample();
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        adv();

        // Back-to-back table stream with no stalls: one accept per cycle, latency 2
        chk_lat = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(vecs[k]);
            sample();
            check("tbl_in_ready", 64'(a_in_ready), 64'd1);
            adv();
        end
        drain();
        chk_lat = 1'b0;
        check("tbl_err_count", 64'(a_err_count), 64'(exp_err_a));
        check("tbl_err_count_sat", 64'(b_err_count), 64'(exp_err_b));

        // Downstream stall for 5 cycles
        out_ready = 1'b0; t0 = cyc; n0 = n_acc; i = 0;
        for (int k = 0; k < 60 && (i < 5 || sb.size() != 0); k++) begin
            if (i < 5) drive(vecs[i]);
            else       in_valid = 1'b0;
            sample();
            if (cyc - t0 >= 2 && cyc - t0 <= 4) begin
                check("stall_hold_imm", 64'(a_imm), 64'hFFFFFF0E);
                check("stall_hold_valid", 64'(a_out_valid), 64'd1);
            end
            if (cyc - t0 == 4) begin
                check("stall_accepts", 64'(n_acc - n0), 64'd2);
                check("stall_in_ready", 64'(a_in_ready), 64'd0);
            end
            if (in_valid && a_in_ready) i++;
            adv();
            if (cyc - t0 == 5) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        check("stall_all_accepted", 64'(i), 64'd5);
        drain();

        // Illegal-type counting and saturation
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        v = '{32'hF0E1D2C3, 3'd6, 32'h0, 1'b1};
        for (int k = 0; k < 3; k++) send(v);
        drain();
        check("illegal_err_count3", 64'(a_err_count), 64'd3);
        check("illegal_err_count3_w2", 64'(b_err_count), 64'd3);
        for (int k = 0; k < 2; k++) send(v);
        drain();
        check("illegal_err_count5", 64'(a_err_count), 64'd5);
        check("illegal_sat_w2", 64'(b_err_count), 64'd3);

        // Flush with two entries in flight plus a same-cycle illegal accept
        drive(vecs[0]); cycle();
        drive(vecs[1]); cycle();
        drive('{32'h0, 3'd5, 32'h0, 1'b1});
        flush = 1'b1;
        sample();
        check("flush_in_ready", 64'(a_in_ready), 64'd1);
        check("flush_inflight", 64'(a_out_valid), 64'd1);
        adv();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("flush_out_valid", 64'(a_out_valid), 64'd0);
            adv();
        end
        check("flush_err_count", 64'(a_err_count), 64'd5);

        // Reset mid-operation with two entries in flight
        out_ready = 1'b0;
        drive(vecs[0]); cycle();
        drive(vecs[1]); cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        sample();
        check("midrst_in_ready", 64'(a_in_ready), 64'd0);
        check("midrst_out_valid", 64'(a_out_valid), 64'd0);
        adv();
        rst_n = 1'b1; out_ready = 1'b1;
        drive(vecs[3]);
        sample();
        check("midrst_after_valid", 64'(a_out_valid), 64'd0);
        check("midrst_after_err_count", 64'(a_err_count), 64'd0);
        check("midrst_after_in_ready", 64'(a_in_ready), 64'd1);
        adv();
        drain();

        // XLEN=64, STAGES=4 variant
        c_in_valid = 1'b1; c_inst = 32'hF0E1D2C3; c_inst_type = 3'd0;
        sample();
        check("c_in_ready", 64'(c_in_ready), 64'd1);
        adv();
        c_inst_type = 3'd3;
        sample();
        check("c_in_ready2", 64'(c_in_ready), 64'd1);
        adv();
        c_in_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            sample();
            if (k < 4) begin
                check("c_latency_idle", 64'(c_out_valid), 64'd0);
            end else if (k == 4) begin
                check("c_valid_i", 64'(c_out_valid), 64'd1);
                check("c_imm_i", c_imm, 64'hFFFFFFFFFFFFFF0E);
                check("c_type_i", 64'({c_out_err, c_out_type}), 64'd0);
            end else begin
                check("c_valid_u", 64'(c_out_valid), 64'd1);
                check("c_imm_u", c_imm, 64'hFFFFFFFFF0E1D000);
                check("c_type_u", 64'({c_out_err, c_out_type}), 64'd3);
            end
            adv();
        end
        sample();
        check("c_empty", 64'(c_out_valid), 64'd0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
